rs_age_select: RTL and testbench

- Parametrised, age-ordered reservation station for the N-way out-of-order RISC-V core.
- Sits between dispatch (rename/ROB) and the functional units.
- Accepts up to N_WAY dispatched ops per cycle and holds them until both source tags are ready.
- Wakeup comes from early execute broadcasts and from the CDB. Up to issue_limit ready ops are issued per cycle, oldest first by order index; the order index wraps.
- Adds whole-station flush, a runtime issue cap and wrap-aware age selection.

---
 rtl/rs_age_select.sv | 201 ++++++++++++++++++++
 tb/tb_rs_age_select.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_select
// Purpose  : Age-ordered reservation station; wakes sources from early/CDB
//            broadcasts and issues up to issue_limit ready ops, oldest first.
// Revision : 1.0
// ============================================================================
module rs_age_select #(
  parameter int N_WAY = 3,
  parameter int N_ENT = 16,
  parameter int TAG_W = 6,
  parameter int OP_W  = 7,
  parameter int AGE_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY-1:0]              disp_valid,
  input  logic [N_WAY*OP_W-1:0]         disp_opcode,
  input  logic [N_WAY*TAG_W-1:0]        disp_dest_tag,
  input  logic [N_WAY*TAG_W-1:0]        disp_src1_tag,
  input  logic [N_WAY-1:0]              disp_src1_rdy,
  input  logic [N_WAY*TAG_W-1:0]        disp_src2_tag,
  input  logic [N_WAY-1:0]              disp_src2_rdy,
  input  logic [N_WAY*AGE_W-1:0]        disp_order,
  input  logic [N_WAY-1:0]              wake_valid,
  input  logic [N_WAY*TAG_W-1:0]        wake_tag,
  input  logic [N_WAY-1:0]              cdb_valid,
  input  logic [N_WAY*TAG_W-1:0]        cdb_tag,
  input  logic                          flush,
  input  logic [$clog2(N_WAY+1)-1:0]    issue_limit,
  output logic [$clog2(N_ENT+1)-1:0]    free_cnt,
  output logic [N_WAY-1:0]              iss_valid,
  output logic [N_WAY*OP_W-1:0]         iss_opcode,
  output logic [N_WAY*TAG_W-1:0]        iss_dest_tag,
  output logic [N_WAY*TAG_W-1:0]        iss_src1_tag,
  output logic [N_WAY*TAG_W-1:0]        iss_src2_tag,
  output logic [N_WAY*AGE_W-1:0]        iss_order
);
  localparam int IDX_W = $clog2(N_ENT);
  localparam int CNT_W = $clog2(N_ENT+1);

  logic [N_ENT-1:0] busy_q, busy_d, s1r_q, s1r_d, s2r_q, s2r_d;
  logic [OP_W-1:0]  op_q   [N_ENT];
  logic [OP_W-1:0]  op_d   [N_ENT];
  logic [TAG_W-1:0] dest_q [N_ENT];
  logic [TAG_W-1:0] dest_d [N_ENT];
  logic [TAG_W-1:0] s1_q   [N_ENT];
  logic [TAG_W-1:0] s1_d   [N_ENT];
  logic [TAG_W-1:0] s2_q   [N_ENT];
  logic [TAG_W-1:0] s2_d   [N_ENT];
  logic [AGE_W-1:0] ord_q  [N_ENT];
  logic [AGE_W-1:0] ord_d  [N_ENT];
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;

  logic [N_ENT-1:0]              cand, issued, alloc_used;
  logic [N_WAY-1:0]              sel_v, disp_ok;
  logic [N_WAY-1:0][IDX_W-1:0]   sel_idx, disp_idx;
  logic [IDX_W-1:0]              best;
  logic                          found, alloc_found;
  int                            lim, busy_n;

  function automatic logic tag_hit(input logic [TAG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < N_WAY; l++) begin
      if ((wake_valid[l] && wake_tag[l*TAG_W +: TAG_W] == tag) ||
          (cdb_valid[l]  && cdb_tag[l*TAG_W +: TAG_W]  == tag))
        hit = 1'b1;
    end
    return hit;
  endfunction

  // Wrap-aware: a is older than b when (a - b) mod 2^AGE_W has its MSB set.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = a - b;
    return d[AGE_W-1];
  endfunction

  assign cand = busy_q & s1r_q & s2r_q;

  always_comb begin
    issued  = '0;
    sel_v   = '0;
    sel_idx = '0;
    found   = 1'b0;
    best    = '0;
    lim     = (int'(issue_limit) > N_WAY) ? N_WAY : int'(issue_limit);
    for (int l = 0; l < N_WAY; l++) begin
      found = 1'b0;
      best  = '0;
      // Strictly-older replacement in ascending index order lets the lower index win ties.
      for (int e = 0; e < N_ENT; e++) begin
        if (cand[e] && !issued[e] && (!found || older(ord_q[e], ord_q[best]))) begin
          found = 1'b1;
          best  = IDX_W'(e);
        end
      end
      if (found && !flush && l < lim) begin
        sel_v[l]     = 1'b1;
        sel_idx[l]   = best;
        issued[best] = 1'b1;
      end
    end
  end

  always_comb begin
    iss_valid    = '0;
    iss_opcode   = '0;
    iss_dest_tag = '0;
    iss_src1_tag = '0;
    iss_src2_tag = '0;
    iss_order    = '0;
    for (int l = 0; l < N_WAY; l++) begin
      if (sel_v[l]) begin
        iss_valid[l]                 = 1'b1;
        iss_opcode[l*OP_W +: OP_W]   = op_q[sel_idx[l]];
        iss_dest_tag[l*TAG_W +: TAG_W] = dest_q[sel_idx[l]];
        iss_src1_tag[l*TAG_W +: TAG_W] = s1_q[sel_idx[l]];
        iss_src2_tag[l*TAG_W +: TAG_W] = s2_q[sel_idx[l]];
        iss_order[l*AGE_W +: AGE_W]  = ord_q[sel_idx[l]];
      end
    end
  end

  always_comb begin
    alloc_used  = '0;
    disp_ok     = '0;
    disp_idx    = '0;
    alloc_found = 1'b0;
    for (int l = 0; l < N_WAY; l++) begin
      alloc_found = 1'b0;
      if (disp_valid[l]) begin
        for (int e = 0; e < N_ENT; e++) begin
          if (!alloc_found && !busy_q[e] && !alloc_used[e]) begin
            alloc_found   = 1'b1;
            disp_idx[l]   = IDX_W'(e);
            alloc_used[e] = 1'b1;
          end
        end
      end
      disp_ok[l] = alloc_found;
    end
  end

  always_comb begin
    busy_d = busy_q & ~issued;
    s1r_d  = s1r_q;
    s2r_d  = s2r_q;
    op_d   = op_q;
    dest_d = dest_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    ord_d  = ord_q;
    busy_n = 0;
    for (int e = 0; e < N_ENT; e++) begin
      if (busy_q[e] && !s1r_q[e] && tag_hit(s1_q[e])) s1r_d[e] = 1'b1;
      if (busy_q[e] && !s2r_q[e] && tag_hit(s2_q[e])) s2r_d[e] = 1'b1;
    end
    for (int l = 0; l < N_WAY; l++) begin
      if (disp_ok[l]) begin
        busy_d[disp_idx[l]] = 1'b1;
        op_d[disp_idx[l]]   = disp_opcode[l*OP_W +: OP_W];
        dest_d[disp_idx[l]] = disp_dest_tag[l*TAG_W +: TAG_W];
        s1_d[disp_idx[l]]   = disp_src1_tag[l*TAG_W +: TAG_W];
        s2_d[disp_idx[l]]   = disp_src2_tag[l*TAG_W +: TAG_W];
        ord_d[disp_idx[l]]  = disp_order[l*AGE_W +: AGE_W];
        s1r_d[disp_idx[l]]  = disp_src1_rdy[l] | tag_hit(disp_src1_tag[l*TAG_W +: TAG_W]);
        s2r_d[disp_idx[l]]  = disp_src2_rdy[l] | tag_hit(disp_src2_tag[l*TAG_W +: TAG_W]);
      end
    end
    if (flush) busy_d = '0;
    for (int e = 0; e < N_ENT; e++) begin
      if (busy_d[e]) busy_n = busy_n + 1;
    end
    free_cnt_d = CNT_W'(N_ENT - busy_n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q     <= '0;
      s1r_q      <= '0;
      s2r_q      <= '0;
      free_cnt_q <= CNT_W'(N_ENT);
    end else begin
      busy_q     <= busy_d;
      s1r_q      <= s1r_d;
      s2r_q      <= s2r_d;
      free_cnt_q <= free_cnt_d;
    end
    op_q   <= op_d;
    dest_q <= dest_d;
    s1_q   <= s1_d;
    s2_q   <= s2_d;
    ord_q  <= ord_d;
  end

  assign free_cnt = free_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_age_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_age_select
// Purpose  : Directed table-driven and hand-sequenced checks of rs_age_select.
// Revision : 1.0
// ============================================================================
module tb_rs_age_select;
  localparam int N_WAY = 3;
  localparam int N_ENT = 16;
  localparam int TAG_W = 6;
  localparam int OP_W  = 7;
  localparam int AGE_W = 8;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [N_WAY-1:0]           disp_valid;
  logic [N_WAY*OP_W-1:0]      disp_opcode;
  logic [N_WAY*TAG_W-1:0]     disp_dest_tag;
  logic [N_WAY*TAG_W-1:0]     disp_src1_tag;
  logic [N_WAY-1:0]           disp_src1_rdy;
  logic [N_WAY*TAG_W-1:0]     disp_src2_tag;
  logic [N_WAY-1:0]           disp_src2_rdy;
  logic [N_WAY*AGE_W-1:0]     disp_order;
  logic [N_WAY-1:0]           wake_valid;
  logic [N_WAY*TAG_W-1:0]     wake_tag;
  logic [N_WAY-1:0]           cdb_valid;
  logic [N_WAY*TAG_W-1:0]     cdb_tag;
  logic                       flush;
  logic [1:0]                 issue_limit;
  logic [4:0]                 free_cnt;
  logic [N_WAY-1:0]           iss_valid;
  logic [N_WAY*OP_W-1:0]      iss_opcode;
  logic [N_WAY*TAG_W-1:0]     iss_dest_tag;
  logic [N_WAY*TAG_W-1:0]     iss_src1_tag;
  logic [N_WAY*TAG_W-1:0]     iss_src2_tag;
  logic [N_WAY*AGE_W-1:0]     iss_order;

  int checks = 0;
  int errors = 0;

  rs_age_select #(.N_WAY(N_WAY), .N_ENT(N_ENT), .TAG_W(TAG_W), .OP_W(OP_W), .AGE_W(AGE_W)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_dest_tag(disp_dest_tag),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_order(disp_order),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .flush(flush), .issue_limit(issue_limit), .free_cnt(free_cnt),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_dest_tag(iss_dest_tag),
    .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag), .iss_order(iss_order)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] dv;
    logic [1:0] lim;
    logic [5:0] d0, d1, d2;
    logic [7:0] o0, o1, o2;
    logic [2:0] ev;
    logic [7:0] e0, e1, e2;
    logic [4:0] efree;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    disp_valid = '0; disp_opcode = '0; disp_dest_tag = '0;
    disp_src1_tag = '0; disp_src1_rdy = '0; disp_src2_tag = '0; disp_src2_rdy = '0;
    disp_order = '0; wake_valid = '0; wake_tag = '0; cdb_valid = '0; cdb_tag = '0;
    flush = 1'b0; issue_limit = 2'd3;
  endtask

  task automatic set_lane(input int l, input logic [5:0] dst, input logic [5:0] s1, input logic r1,
                          input logic [5:0] s2, input logic r2, input logic [7:0] ord);
    disp_valid[l] = 1'b1;
    disp_opcode[l*OP_W +: OP_W]     = 7'(l + 1);
    disp_dest_tag[l*TAG_W +: TAG_W] = dst;
    disp_src1_tag[l*TAG_W +: TAG_W] = s1;
    disp_src1_rdy[l] = r1;
    disp_src2_tag[l*TAG_W +: TAG_W] = s2;
    disp_src2_rdy[l] = r2;
    disp_order[l*AGE_W +: AGE_W]    = ord;
  endtask

  initial begin
    logic [5:0] d [3];
    logic [7:0] o [3];
    logic [7:0] eo [3];

    tbl[0] = '{3'b000, 2'd3, 0, 0, 0, 0, 0, 0,       3'b000, 0, 0, 0, 16};
    tbl[1] = '{3'b111, 2'd3, 33, 34, 35, 1, 2, 3,    3'b000, 0, 0, 0, 16};
    tbl[2] = '{3'b000, 2'd3, 0, 0, 0, 0, 0, 0,       3'b111, 1, 2, 3, 13};
    tbl[3] = '{3'b000, 2'd3, 0, 0, 0, 0, 0, 0,       3'b000, 0, 0, 0, 16};
    tbl[4] = '{3'b111, 2'd1, 41, 42, 43, 0, 255, 254, 3'b000, 0, 0, 0, 16};
    tbl[5] = '{3'b000, 2'd0, 0, 0, 0, 0, 0, 0,       3'b000, 0, 0, 0, 13};
    tbl[6] = '{3'b000, 2'd1, 0, 0, 0, 0, 0, 0,       3'b001, 254, 0, 0, 13};
    tbl[7] = '{3'b000, 2'd1, 0, 0, 0, 0, 0, 0,       3'b001, 255, 0, 0, 14};
    tbl[8] = '{3'b000, 2'd1, 0, 0, 0, 0, 0, 0,       3'b001, 0, 0, 0, 15};
    tbl[9] = '{3'b000, 2'd3, 0, 0, 0, 0, 0, 0,       3'b000, 0, 0, 0, 16};

    clr();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset_free", 32'(free_cnt), 16);
    chk("reset_valid", 32'(iss_valid), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      clr();
      issue_limit = tbl[i].lim;
      d[0] = tbl[i].d0; d[1] = tbl[i].d1; d[2] = tbl[i].d2;
      o[0] = tbl[i].o0; o[1] = tbl[i].o1; o[2] = tbl[i].o2;
      eo[0] = tbl[i].e0; eo[1] = tbl[i].e1; eo[2] = tbl[i].e2;
      for (int l = 0; l < N_WAY; l++)
        if (tbl[i].dv[l]) set_lane(l, d[l], 6'd1, 1'b1, 6'd2, 1'b1, o[l]);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(iss_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_free", i), 32'(free_cnt), 32'(tbl[i].efree));
      for (int l = 0; l < N_WAY; l++)
        if (tbl[i].ev[l])
          chk($sformatf("tbl%0d_order_l%0d", i, l), 32'(iss_order[l*AGE_W +: AGE_W]), 32'(eo[l]));
      if (i == 2)
        chk("tbl2_dest", 32'(iss_dest_tag), 32'({6'd35, 6'd34, 6'd33}));
    end

    // CDB wakeup: issue appears only in the cycle after the broadcast.
    @(negedge clock); clr();
    set_lane(0, 6'd36, 6'd33, 1'b0, 6'd5, 1'b1, 8'd10);
    @(negedge clock); clr();
    wake_tag = {3{6'd33}}; cdb_tag = {3{6'd33}};
    #1; chk("cdb_wait_valid", 32'(iss_valid), 0);
    chk("cdb_wait_free", 32'(free_cnt), 15);
    @(negedge clock); clr();
    cdb_valid[0] = 1'b1; cdb_tag[5:0] = 6'd33;
    #1; chk("cdb_not_early", 32'(iss_valid), 0);
    @(negedge clock); clr();
    #1; chk("cdb_issue_valid", 32'(iss_valid), 1);
    chk("cdb_issue_dest", 32'(iss_dest_tag[5:0]), 36);
    @(negedge clock); clr();
    #1; chk("cdb_after_free", 32'(free_cnt), 16);
    chk("cdb_after_valid", 32'(iss_valid), 0);

    // Same-cycle bypass from an early wakeup lane.
    @(negedge clock); clr();
    set_lane(0, 6'd40, 6'd39, 1'b0, 6'd6, 1'b1, 8'd20);
    wake_valid = 3'b010; wake_tag[11:6] = 6'd39;
    @(negedge clock); clr();
    #1; chk("bypass_valid", 32'(iss_valid), 1);
    chk("bypass_dest", 32'(iss_dest_tag[5:0]), 40);
    @(negedge clock); clr();
    #1; chk("bypass_free", 32'(free_cnt), 16);

    // Fill, overflow drop, then flush.
    for (int c = 0; c < 6; c++) begin
      @(negedge clock); clr();
      for (int l = 0; l < N_WAY; l++)
        if (c*3 + l < 16) set_lane(l, 6'(c*3 + l), 6'd50, 1'b0, 6'd51, 1'b1, 8'(100 + c*3 + l));
    end
    @(negedge clock); clr();
    for (int l = 0; l < N_WAY; l++) set_lane(l, 6'(60 + l), 6'd1, 1'b1, 6'd2, 1'b1, 8'(l));
    #1; chk("full_free", 32'(free_cnt), 0);
    chk("full_valid", 32'(iss_valid), 0);
    @(negedge clock); clr();
    cdb_valid[2] = 1'b1; cdb_tag[17:12] = 6'd50;
    #1; chk("drop_free", 32'(free_cnt), 0);
    chk("drop_valid", 32'(iss_valid), 0);
    @(negedge clock); clr();
    flush = 1'b1;
    set_lane(0, 6'd63, 6'd1, 1'b1, 6'd2, 1'b1, 8'd7);
    #1; chk("flush_gate", 32'(iss_valid), 0);
    @(negedge clock); clr();
    #1; chk("post_flush_free", 32'(free_cnt), 16);
    chk("post_flush_valid", 32'(iss_valid), 0);
    @(negedge clock); clr();
    #1; chk("post_flush_valid2", 32'(iss_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
